// File: rtl/alu_6502_pkg.sv
// Shared definitions for the sequential 6502 ALU: one-hot operation codes and FSM states.
package alu_6502_pkg;

  localparam logic [4:0] SUMS = 5'b10000;
  localparam logic [4:0] ORS  = 5'b01000;
  localparam logic [4:0] XORS = 5'b00100;
  localparam logic [4:0] ANDS = 5'b00010;
  localparam logic [4:0] SRS  = 5'b00001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_6502_core.sv
// Combinational datapath: add-with-carry plus bitwise OR/XOR/AND results.
module alu_6502_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic [WIDTH-1:0] or_c,
  output logic [WIDTH-1:0] xor_c,
  output logic [WIDTH-1:0] and_c,
  output logic             carry_c,
  output logic             overflow_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] wide_c;

  assign wide_c     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum_c      = wide_c[WIDTH-1:0];
  assign carry_c    = wide_c[WIDTH];
  // Signed overflow: operands agree in sign but the result does not.
  assign overflow_c = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
  assign or_c       = a | b;
  assign xor_c      = a ^ b;
  assign and_c      = a & b;

endmodule

// File: rtl/alu_seq_6502.sv
// Registered 6502-style ALU with persistent N/V/Z/C flags, valid handshake and
// an iterative one-bit-per-cycle right shifter.
module alu_seq_6502 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [4:0]       control,
  input  logic             carryIn,
  output logic             outValid,
  output logic [WIDTH-1:0] regOut,
  output logic             overflow,
  output logic             carry,
  output logic             negative,
  output logic             zero,
  output logic             illegal
);

  import alu_6502_pkg::*;

  localparam int unsigned  MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic             beyond;

  logic [WIDTH-1:0] sum_c, or_c, xor_c, and_c, res_c, shifted_c;
  logic             sum_carry_c, sum_ovf_c;

  alu_6502_core #(.WIDTH(WIDTH)) u_core (
    .a          (regA),
    .b          (regB),
    .cin        (carryIn),
    .sum_c      (sum_c),
    .or_c       (or_c),
    .xor_c      (xor_c),
    .and_c      (and_c),
    .carry_c    (sum_carry_c),
    .overflow_c (sum_ovf_c)
  );

  // Single-cycle result select; SR by zero passes A through.
  always_comb begin
    res_c = '0;
    case (control)
      SUMS:    res_c = sum_c;
      ORS:     res_c = or_c;
      XORS:    res_c = xor_c;
      ANDS:    res_c = and_c;
      SRS:     res_c = regA;
      default: res_c = '0;
    endcase
  end

  assign shifted_c = {1'b0, work[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      count    <= '0;
      beyond   <= 1'b0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      regOut   <= '0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            inReady <= 1'b0;
            case (control)
              SUMS, ORS, XORS, ANDS: begin
                regOut   <= res_c;
                negative <= res_c[MSB];
                zero     <= (res_c == '0);
                if (control == SUMS) begin
                  carry    <= sum_carry_c;
                  overflow <= sum_ovf_c;
                end
                outValid <= 1'b1;
                state    <= DONE;
              end
              SRS: begin
                if (regB == '0) begin
                  regOut   <= res_c;
                  negative <= res_c[MSB];
                  zero     <= (res_c == '0);
                  carry    <= 1'b0;
                  outValid <= 1'b1;
                  state    <= DONE;
                end else begin
                  // Shifts longer than the word saturate to WIDTH steps with no carry out.
                  work   <= regA;
                  beyond <= (regB > WLIM);
                  count  <= (regB > WLIM) ? SHW'(WIDTH) : SHW'(regB);
                  state  <= SHIFT;
                end
              end
              default: begin
                illegal  <= 1'b1;
                outValid <= 1'b1;
                state    <= DONE;
              end
            endcase
          end
        end
        SHIFT: begin
          work  <= shifted_c;
          count <= count - SHW'(1);
          if (count == SHW'(1)) begin
            regOut   <= shifted_c;
            carry    <= work[0] & ~beyond;
            negative <= shifted_c[MSB];
            zero     <= (shifted_c == '0);
            outValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          outValid <= 1'b0;
          illegal  <= 1'b0;
          inReady  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
